// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry engine: key codes, operator encoding
// and the control FSM state type.
package calc_pkg;

  localparam logic [3:0] KeyClear     = 4'hA;
  localparam logic [3:0] KeyAdd       = 4'hB;
  localparam logic [3:0] KeySub       = 4'hC;
  localparam logic [3:0] KeyResult    = 4'hD;
  localparam logic [3:0] KeyMemStore  = 4'hE;
  localparam logic [3:0] KeyMemRecall = 4'hF;

  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpAdd  = 2'b01,
    OpSub  = 2'b10
  } op_e;

  typedef enum logic [1:0] {
    StEntry  = 2'b00,
    StExec   = 2'b01,
    StResult = 2'b10
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational saturating add/sub; with no operator it passes b through so the
// first operand of a chain simply loads the accumulator.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [1:0]              op,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat
);

  localparam logic signed [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] ext;

  always_comb begin
    ext = '0;
    y   = b;
    sat = 1'b0;
    case (op)
      OpAdd:   ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      OpSub:   ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      default: ext = {b[WIDTH-1], b};
    endcase
    // Top two bits disagree only when the true result left the WIDTH-bit range.
    if (ext[WIDTH] != ext[WIDTH-1]) begin
      sat = 1'b1;
      y   = ext[WIDTH] ? MinVal : MaxVal;
    end else begin
      y = ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/calc_entry_engine.sv
// Calculator key-entry engine: digit entry, chained add/sub with saturation,
// one-slot memory, and a one-cycle EXEC state that applies the pending operator.
module calc_entry_engine
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] display,
  output logic             overflow,
  output logic             mem_valid,
  output logic [1:0]       op_pending
);

  localparam int unsigned      CntW     = $clog2(DIGITS + 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(DIGITS);
  localparam int unsigned      MinWidth = $clog2(64'(10) ** DIGITS) + 1;

  if (WIDTH < MinWidth) begin : g_width_check
    $error("calc_entry_engine: WIDTH too small to hold DIGITS decimal digits plus sign");
  end

  state_e                  state_q;
  logic signed [WIDTH-1:0] acc_q, entry_q, mem_q;
  logic [CntW-1:0]         cnt_q;
  op_e                     op_q, exec_op_q, next_op_q;
  logic                    ovf_q, memv_q, to_result_q;

  logic signed [WIDTH-1:0] disp_w, alu_y, key_val, entry_next;
  logic                    alu_sat;
  op_e                     key_op;

  assign key_val    = $signed({{(WIDTH-4){1'b0}}, key_code});
  assign entry_next = (entry_q <<< 3) + (entry_q <<< 1) + key_val;
  assign key_op     = (key_code == KeySub) ? OpSub : OpAdd;
  assign disp_w     = (state_q == StEntry && cnt_q != '0) ? entry_q : acc_q;

  assign key_ready  = (state_q != StExec);
  assign display    = disp_w;
  assign overflow   = ovf_q;
  assign mem_valid  = memv_q;
  assign op_pending = op_q;

  calc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a   (acc_q),
    .b   (entry_q),
    .op  (exec_op_q),
    .y   (alu_y),
    .sat (alu_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEntry;
      acc_q       <= '0;
      entry_q     <= '0;
      mem_q       <= '0;
      cnt_q       <= '0;
      op_q        <= OpNone;
      exec_op_q   <= OpNone;
      next_op_q   <= OpNone;
      ovf_q       <= 1'b0;
      memv_q      <= 1'b0;
      to_result_q <= 1'b0;
    end else begin
      case (state_q)
        StExec: begin
          acc_q   <= alu_y;
          entry_q <= '0;
          cnt_q   <= '0;
          op_q    <= next_op_q;
          if (alu_sat) ovf_q <= 1'b1;
          state_q <= to_result_q ? StResult : StEntry;
        end
        StEntry, StResult: begin
          if (key_valid) begin
            if (is_digit(key_code)) begin
              if (state_q == StResult) begin
                entry_q <= key_val;
                cnt_q   <= CntW'(1);
                acc_q   <= '0;
                state_q <= StEntry;
              end else if (cnt_q < CntMax) begin
                entry_q <= entry_next;
                cnt_q   <= cnt_q + CntW'(1);
              end
            end else begin
              case (key_code)
                KeyClear: begin
                  acc_q   <= '0;
                  entry_q <= '0;
                  cnt_q   <= '0;
                  op_q    <= OpNone;
                  ovf_q   <= 1'b0;
                  state_q <= StEntry;
                end
                KeyAdd, KeySub: begin
                  if (state_q == StResult) begin
                    // Entry is zero here, so adding it keeps the previous result.
                    exec_op_q   <= OpAdd;
                    next_op_q   <= key_op;
                    to_result_q <= 1'b0;
                    state_q     <= StExec;
                  end else if (cnt_q != '0) begin
                    exec_op_q   <= op_q;
                    next_op_q   <= key_op;
                    to_result_q <= 1'b0;
                    state_q     <= StExec;
                  end else begin
                    op_q <= key_op;
                  end
                end
                KeyResult: begin
                  if (state_q == StEntry) begin
                    exec_op_q   <= op_q;
                    next_op_q   <= OpNone;
                    to_result_q <= 1'b1;
                    state_q     <= StExec;
                  end
                end
                KeyMemStore: begin
                  mem_q  <= disp_w;
                  memv_q <= 1'b1;
                end
                KeyMemRecall: begin
                  if (memv_q) begin
                    entry_q <= mem_q;
                    cnt_q   <= CntMax;
                    state_q <= StEntry;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        default: state_q <= StEntry;
      endcase
    end
  end

endmodule
